// File: rtl/pipe_wb_bank.sv
// pipe_wb_bank: multi-channel MEM/WB pipeline register. It sanitises each
// write record (x0 suppression, duplicate-destination resolution and idle
// zeroing), follows the core stall-vector protocol, and keeps saturating
// hold and bubble counters for the performance monitor.
module pipe_wb_bank #(
  parameter int STAGE   = 4,
  parameter int STALL_W = 6,
  parameter int NCH     = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [NCH*AW-1:0]  mem_reg_waddr,
  input  logic [NCH-1:0]     mem_we,
  input  logic [NCH*DW-1:0]  mem_reg_wdata,
  output logic [NCH*AW-1:0]  wb_reg_waddr,
  output logic [NCH-1:0]     wb_we,
  output logic [NCH*DW-1:0]  wb_reg_wdata,
  output logic               wb_any_we,
  output logic               dup_err,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [NCH*AW-1:0] waddr_q, waddr_d;
  logic [NCH*DW-1:0] wdata_q, wdata_d;
  logic [NCH-1:0]    we_q, we_d;
  logic [NCH-1:0]    we_raw, kill;
  logic              any_q, dup_q, dup_d;
  logic [CNT_W-1:0]  hold_q, bubble_q;

  logic stall_here, stall_down;
  assign stall_here = stall[STAGE];
  assign stall_down = stall[STAGE+1];

  // Sanitise the incoming records. A channel loses its write if it targets
  // x0 or if a younger (higher-index) channel writes the same register.
  always_comb begin
    we_raw  = '0;
    kill    = '0;
    we_d    = '0;
    waddr_d = '0;
    wdata_d = '0;
    for (int i = 0; i < NCH; i++)
      we_raw[i] = mem_we[i] && (mem_reg_waddr[i*AW +: AW] != '0);
    for (int i = 0; i < NCH; i++)
      for (int j = i + 1; j < NCH; j++)
        if (we_raw[i] && we_raw[j] &&
            (mem_reg_waddr[i*AW +: AW] == mem_reg_waddr[j*AW +: AW]))
          kill[i] = 1'b1;
    we_d  = we_raw & ~kill;
    dup_d = |kill;
    for (int i = 0; i < NCH; i++) begin
      if (we_d[i]) begin
        waddr_d[i*AW +: AW] = mem_reg_waddr[i*AW +: AW];
        wdata_d[i*DW +: DW] = mem_reg_wdata[i*DW +: DW];
      end
    end
  end

  // Register update by priority: reset, flush, bubble, hold, load.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      any_q    <= 1'b0;
      dup_q    <= 1'b0;
      hold_q   <= '0;
      bubble_q <= '0;
    end else if (flush) begin
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      any_q   <= 1'b0;
    end else if (stall_here && !stall_down) begin
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      any_q   <= 1'b0;
      if (bubble_q != '1) bubble_q <= bubble_q + 1'b1;
    end else if (stall_here) begin
      if (hold_q != '1) hold_q <= hold_q + 1'b1;
    end else begin
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      any_q   <= |we_d;
      if (dup_d) dup_q <= 1'b1;
    end
  end

  assign wb_reg_waddr = waddr_q;
  assign wb_reg_wdata = wdata_q;
  assign wb_we        = we_q;
  assign wb_any_we    = any_q;
  assign dup_err      = dup_q;
  assign hold_cnt     = hold_q;
  assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_pipe_wb_bank.sv
// Directed bench for pipe_wb_bank: NCH=2, CNT_W=4 so saturation is reachable.
module tb_pipe_wb_bank;
  localparam int STAGE = 4, STALL_W = 6, NCH = 2, AW = 5, DW = 32, CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [NCH*AW-1:0]  mem_reg_waddr;
  logic [NCH-1:0]     mem_we;
  logic [NCH*DW-1:0]  mem_reg_wdata;
  logic [NCH*AW-1:0]  wb_reg_waddr;
  logic [NCH-1:0]     wb_we;
  logic [NCH*DW-1:0]  wb_reg_wdata;
  logic               wb_any_we;
  logic               dup_err;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  int checks = 0;
  int failures = 0;

  pipe_wb_bank #(.STAGE(STAGE), .STALL_W(STALL_W), .NCH(NCH), .AW(AW),
                 .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
    .wb_any_we(wb_any_we), .dup_err(dup_err),
    .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [9:0] a, input logic [1:0] w,
                           input logic [63:0] d, input logic any);
    check({tag, ".waddr"}, 64'(wb_reg_waddr), 64'(a));
    check({tag, ".we"},    64'(wb_we),        64'(w));
    check({tag, ".wdata"}, wb_reg_wdata,      d);
    check({tag, ".any"},   64'(wb_any_we),    64'(any));
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    mem_reg_waddr = '0; mem_we = '0; mem_reg_wdata = '0;
    step();
    rst = 1'b0;
    check_rec("reset", 10'd0, 2'b00, 64'd0, 1'b0);
    check("reset.dup", 64'(dup_err), 64'd0);
    check("reset.hold", 64'(hold_cnt), 64'd0);
    check("reset.bubble", 64'(bubble_cnt), 64'd0);

    // Load two valid channels
    mem_reg_waddr = {5'd7, 5'd5}; mem_we = 2'b11;
    mem_reg_wdata = {32'h12345678, 32'hDEADBEEF};
    step();
    check_rec("load", {5'd7, 5'd5}, 2'b11, {32'h12345678, 32'hDEADBEEF}, 1'b1);

    // Hold three cycles while inputs change
    stall = 6'b110000;
    mem_reg_waddr = {5'd1, 5'd2}; mem_reg_wdata = {32'h1, 32'h2};
    for (int k = 0; k < 3; k++) begin
      step();
      check_rec("hold", {5'd7, 5'd5}, 2'b11, {32'h12345678, 32'hDEADBEEF}, 1'b1);
    end
    check("hold.cnt", 64'(hold_cnt), 64'd3);
    check("hold.bubble", 64'(bubble_cnt), 64'd0);

    // Bubble
    stall = 6'b010000;
    step();
    check_rec("bubble", 10'd0, 2'b00, 64'd0, 1'b0);
    check("bubble.cnt", 64'(bubble_cnt), 64'd1);
    check("bubble.hold", 64'(hold_cnt), 64'd3);

    // x0 suppression and idle canonicalisation
    stall = '0;
    mem_reg_waddr = {5'd3, 5'd0}; mem_we = 2'b01;
    mem_reg_wdata = {32'h0000AAAA, 32'hFFFFFFFF};
    step();
    check_rec("x0", 10'd0, 2'b00, 64'd0, 1'b0);
    check("x0.dup", 64'(dup_err), 64'd0);

    // Duplicate destination: ch1 wins
    mem_reg_waddr = {5'd9, 5'd9}; mem_we = 2'b11;
    mem_reg_wdata = {32'h2, 32'h1};
    step();
    check_rec("dup", {5'd9, 5'd0}, 2'b10, {32'h2, 32'h0}, 1'b1);
    check("dup.err", 64'(dup_err), 64'd1);

    // Load distinct valid data, then flush while hold pattern is applied
    mem_reg_waddr = {5'd5, 5'd4}; mem_we = 2'b11;
    mem_reg_wdata = {32'h55, 32'h44};
    step();
    check_rec("load2", {5'd5, 5'd4}, 2'b11, {32'h55, 32'h44}, 1'b1);
    check("load2.dup", 64'(dup_err), 64'd1);
    flush = 1'b1; stall = 6'b110000;
    step();
    check_rec("flush", 10'd0, 2'b00, 64'd0, 1'b0);
    check("flush.hold", 64'(hold_cnt), 64'd3);
    check("flush.bubble", 64'(bubble_cnt), 64'd1);
    check("flush.dup", 64'(dup_err), 64'd1);

    // Flush with bubble pattern: no bubble count
    stall = 6'b010000;
    step();
    check("flushb.bubble", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;

    // Hold saturation: 3 + 20 clamps at 15
    stall = 6'b110000;
    for (int k = 0; k < 12; k++) step();
    check("sat.exact", 64'(hold_cnt), 64'd15);
    for (int k = 0; k < 8; k++) step();
    check("sat.hold", 64'(hold_cnt), 64'd15);
    check("sat.bubble", 64'(bubble_cnt), 64'd1);

    // Reset mid-hold
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_rec("rst2", 10'd0, 2'b00, 64'd0, 1'b0);
    check("rst2.dup", 64'(dup_err), 64'd0);
    check("rst2.hold", 64'(hold_cnt), 64'd0);
    check("rst2.bubble", 64'(bubble_cnt), 64'd0);

    // First load after reset happens when stall[STAGE] drops
    mem_reg_waddr = {5'd0, 5'd31}; mem_we = 2'b11;
    mem_reg_wdata = {32'hCAFE, 32'hBEEF};
    step();
    check_rec("post.hold", 10'd0, 2'b00, 64'd0, 1'b0);
    check("post.holdcnt", 64'(hold_cnt), 64'd1);
    stall = '0;
    step();
    check_rec("post.load", {5'd0, 5'd31}, 2'b01, {32'h0, 32'hBEEF}, 1'b1);
    check("post.dup", 64'(dup_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_wb_bank.md
# pipe_wb_bank

Parametrised, multi-channel MEM/WB pipeline register for the RISC-V core. It carries NCH independent register-write records from the memory stage to the register-file write port. It uses the core-wide stall-vector protocol: hold, bubble insertion, and an explicit flush. It also adds two features: x0-write suppression and same-cycle duplicate-destination resolution. Saturating hold and bubble counters feed the performance monitor.

## Interface
Parameters:
- STAGE, 4, index of this stage in the stall vector; stall[STAGE] holds this stage, stall[STAGE+1] is the downstream stage.
- STALL_W, 6, stall vector width; must satisfy STALL_W >= STAGE+2.
- NCH, 2, number of write channels (1..4).
- AW, 5, register address width.
- DW, 32, register data width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  core stall vector.
- flush  in  1  kill the in-flight records (exception/redirect).
- mem_reg_waddr  in  NCH*AW  destination per channel; channel i occupies bits [i*AW +: AW].
- mem_we  in  NCH  write enable per channel.
- mem_reg_wdata  in  NCH*DW  write data per channel; channel i occupies bits [i*DW +: DW].
- wb_reg_waddr  out  NCH*AW  registered destination.
- wb_we  out  NCH  registered, sanitised write enable.
- wb_reg_wdata  out  NCH*DW  registered data.
- wb_any_we  out  1  registered OR of all wb_we bits.
- dup_err  out  1  sticky flag; set when a duplicate destination was resolved.
- hold_cnt  out  CNT_W  count of hold cycles.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

## Operation
- The register-update action is chosen per cycle by strict priority:
  1. rst: all outputs go to 0, including dup_err and both counters.
  2. flush: wb_we, wb_reg_waddr, wb_reg_wdata and wb_any_we go to 0. Counters and dup_err are unchanged.
  3. Bubble (stall[STAGE]=1 and stall[STAGE+1]=0): record outputs go to 0, and bubble_cnt increments.
  4. Hold (stall[STAGE]=1 and stall[STAGE+1]=1): all record outputs keep their values, and hold_cnt increments.
  5. Load (stall[STAGE]=0): sanitised inputs are captured.
- Sanitisation on load, per channel i:
  - Set eff_we[i] = mem_we[i] AND (waddr_i != 0). This suppresses writes to x0.
  - Duplicate resolution: if eff_we[i] and eff_we[j] are both 1 for some j>i with waddr_j == waddr_i, clear eff_we[i]. The highest channel index wins, because it is youngest in program order. Also set dup_err.
  - Idle canonicalisation: for every channel with eff_we[i]=0, capture waddr and wdata as 0.
  - Then wb_we <= eff_we, and wb_any_we <= |eff_we.
- dup_err is sticky. It is cleared only by rst. It is set only on a load cycle in which a resolution occurred; flush, bubble and hold never set it.
- Counters saturate at all-ones; they never wrap. Flush does not increment either counter, even when stall bits are also set.
- With NCH=1 and x0 inputs avoided, record behaviour equals the existing single-channel MEM/WB register.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N and are stable until the next update.
- All outputs are registered. No combinational path exists from any input to any output.
- Simultaneous flush and stall: flush wins. Outputs are zeroed and no counter increments.
- Reset asserted mid-hold: the next edge zeroes everything. Held data is lost by design.
- After rst deasserts, the first load occurs on the first edge with stall[STAGE]=0.
- Counter saturation: at 2^CNT_W-1, a further qualifying cycle leaves the value unchanged.

## Test plan
- Load and hold, NCH=2: load ch0 (5, we=1, 0xDEADBEEF) and ch1 (7, we=1, 0x12345678), then stall=6'b110000 for 3 cycles -> outputs stay identical for all 3 cycles, hold_cnt=3, wb_any_we=1.
- Bubble: with valid data loaded, apply stall=6'b010000 -> next cycle wb_we=0, wb_reg_waddr=0, wb_reg_wdata=0, bubble_cnt=1.
- x0 suppression and canonicalisation: ch0 (0, we=1, 0xFFFFFFFF), ch1 (3, we=0, 0xAAAA) -> wb_we=2'b00, all addresses and data 0, wb_any_we=0.
- Duplicate resolution: both channels target 9 with we=1, data ch0=1 and ch1=2 -> wb_we=2'b10, ch1 data 2, ch0 fields 0, dup_err=1. dup_err stays 1 after a later flush and clears only on rst.
- Flush priority: flush=1 with stall=6'b110000 and valid data held -> outputs zeroed, hold_cnt unchanged.
- Saturation: with CNT_W=4, hold for 20 cycles -> hold_cnt=15. Then rst=1 for 1 cycle -> every output is 0.
